// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the SD sector arbiter.
package sd_arb_pkg;

  localparam int LBA_W  = 32;
  localparam int BIDX_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               vld
);

  logic [IW-1:0] j;

  // Scan farthest-to-nearest so the nearest hit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        idx = j;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector-read engine between NUM_REQ requesters: round-robin grant,
// per-requester image base offset, byte-strobe demux and a grant-to-rdone timeout.
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter logic [23:0] TIMEOUT = 24'd8000000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_rd,
  input  logic [LBA_W*NUM_REQ-1:0] req_lba,
  input  logic [LBA_W*NUM_REQ-1:0] req_base,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [NUM_REQ-1:0]       req_err,
  output logic [NUM_REQ-1:0]       req_strobe,
  output logic [BIDX_W-1:0]        buf_addr,
  output logic [7:0]               buf_data,
  output logic                     sd_rstart,
  output logic [LBA_W-1:0]         sd_rsector,
  input  logic                     sd_rbusy,
  input  logic                     sd_rdone,
  input  logic                     sd_outen,
  input  logic [BIDX_W-1:0]        sd_outaddr,
  input  logic [7:0]               sd_outbyte
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                    state_q, state_d;
  logic [IW-1:0]                 gnt_q, gnt_d, rr_q, rr_d;
  logic [IW-1:0]                 pick_idx;
  logic                          pick_vld;
  logic [LBA_W-1:0]              sector_q, sector_d;
  logic [23:0]                   cnt_q, cnt_d;
  logic                          done_q, done_d, err_q, err_d;
  logic                          tmo;
  logic [NUM_REQ-1:0]            gnt_oh;
  logic [NUM_REQ-1:0][LBA_W-1:0] lba_a, base_a;

  assign lba_a  = req_lba;
  assign base_a = req_base;
  assign gnt_oh = NUM_REQ'(1) << gnt_q;
  assign tmo    = (TIMEOUT != 24'd0) && (cnt_q + 24'd1 == TIMEOUT);

  assign buf_addr   = sd_outaddr;
  assign buf_data   = sd_outbyte;
  assign sd_rsector = sector_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_rd),
    .ptr (rr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      sector_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      sector_q <= sector_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    sector_d = sector_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Engine may still be busy from a transfer cut short by reset.
        if (pick_vld && !sd_rbusy) begin
          state_d  = START;
          gnt_d    = pick_idx;
          rr_d     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          sector_d = base_a[pick_idx] + lba_a[pick_idx];
          cnt_d    = '0;
        end
      end
      START, XFER: begin
        // A real rdone wins over a coincident timeout.
        if (sd_rdone) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end else if (tmo) begin
          state_d = DRAIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
          if (state_q == START && sd_rbusy) state_d = XFER;
        end
      end
      DRAIN: begin
        if (!sd_rbusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ack    = '0;
    req_done   = '0;
    req_err    = '0;
    req_strobe = '0;
    sd_rstart  = 1'b0;
    if (state_q != IDLE)  req_ack   = gnt_oh;
    if (state_q == START) sd_rstart = 1'b1;
    if ((state_q == START || state_q == XFER) && sd_outen) req_strobe = gnt_oh;
    if (done_q) req_done = gnt_oh;
    if (err_q)  req_err  = gnt_oh;
  end

endmodule
